// File: rtl/l1_dcache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : l1_dcache_ctrl_pkg
//  Purpose : Shared constants and types for the L1 data-cache controller:
//            processor/memory request encoding (IOSTATE), default address
//            and word widths, controller FSM state encoding, and the
//            saturating counter helper used by the optional statistics.
//  Ports   : none (package)
//  Options : L1_DCACHE_STATS_EN (consumers only; nothing here is gated)
//  Rev     : 1.0  initial release
// ============================================================================
package l1_dcache_ctrl_pkg;

    // Request encoding shared by the processor port and the memory port.
    // 2'd3 is not a legal request and is treated like IDLE by the cache.
    localparam int                   IOSTATE_W = 2;
    localparam logic [IOSTATE_W-1:0] IO_IDLE   = 2'd0;
    localparam logic [IOSTATE_W-1:0] IO_RD     = 2'd1;
    localparam logic [IOSTATE_W-1:0] IO_WT     = 2'd2;

    localparam int DC_ADDR_W  = 8;
    localparam int DC_WORD_W  = 8;
    localparam int DC_INDEX_W = 4;

    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_FILL   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    localparam int CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l1_dcache_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : l1_dcache_ctrl_if
//  Purpose : Bundles the processor-side and memory-side handshake of the
//            L1 data cache.
//  Signals : cpu_rw/cpu_addr/cpu_wdata   request from the processor
//            cpu_rdata/cpu_rd_en/cpu_wt_en  completion back to the processor
//            mem_rw/mem_addr/mem_wdata   request to main memory
//            mem_rd_done/mem_wt_done/mem_rdata  completion from main memory
//  Modports: slave  - the cache controller
//            master - the environment (processor + memory)
//  Rev     : 1.0  initial release
// ============================================================================
interface l1_dcache_ctrl_if #(
    parameter int ADDR_W = l1_dcache_ctrl_pkg::DC_ADDR_W,
    parameter int WORD_W = l1_dcache_ctrl_pkg::DC_WORD_W
) ();
    logic [l1_dcache_ctrl_pkg::IOSTATE_W-1:0] cpu_rw;
    logic [ADDR_W-1:0]                        cpu_addr;
    logic [WORD_W-1:0]                        cpu_wdata;
    logic [WORD_W-1:0]                        cpu_rdata;
    logic                                     cpu_rd_en;
    logic                                     cpu_wt_en;
    logic [l1_dcache_ctrl_pkg::IOSTATE_W-1:0] mem_rw;
    logic [ADDR_W-1:0]                        mem_addr;
    logic [WORD_W-1:0]                        mem_wdata;
    logic                                     mem_rd_done;
    logic                                     mem_wt_done;
    logic [WORD_W-1:0]                        mem_rdata;

    modport slave (
        input  cpu_rw, cpu_addr, cpu_wdata, mem_rd_done, mem_wt_done, mem_rdata,
        output cpu_rdata, cpu_rd_en, cpu_wt_en, mem_rw, mem_addr, mem_wdata
    );

    modport master (
        output cpu_rw, cpu_addr, cpu_wdata, mem_rd_done, mem_wt_done, mem_rdata,
        input  cpu_rdata, cpu_rd_en, cpu_wt_en, mem_rw, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/l1_dcache_ctrl_array.sv
`default_nettype none
// ============================================================================
//  Module  : l1_dcache_array
//  Purpose : Valid/tag/data storage for a direct-mapped cache with one word
//            per line. Combinational read port, synchronous write port.
//            Reset clears only the valid bits; tag/data are don't-care
//            while their line is invalid.
//  Ports   : clk, reset           clock, synchronous active-high reset
//            i_rd_index           line selected for lookup
//            o_rd_valid/tag/data  contents of that line (combinational)
//            i_we, i_wr_index/tag/data  line write (sets valid)
//  Rev     : 1.0  initial release
// ============================================================================
module l1_dcache_array #(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 4,
    parameter int WORD_W  = 8
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic [INDEX_W-1:0] i_rd_index,
    output logic                    o_rd_valid,
    output logic [TAG_W-1:0]        o_rd_tag,
    output logic [WORD_W-1:0]       o_rd_data,
    input  wire logic               i_we,
    input  wire logic [INDEX_W-1:0] i_wr_index,
    input  wire logic [TAG_W-1:0]   i_wr_tag,
    input  wire logic [WORD_W-1:0]  i_wr_data
);
    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [WORD_W-1:0] r_data [LINES];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];
endmodule
`default_nettype wire

// File: rtl/l1_dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : l1_dcache_ctrl
//  Purpose : Direct-mapped, write-through, no-write-allocate L1 data cache.
//            Transparent to the processor: same request/complete handshake
//            as a bare memory. Read hits complete without a memory access;
//            every write is forwarded to memory and updates the line only
//            if it is already cached.
//  Ports   : clk, reset  clock, synchronous active-high reset
//            bus         l1_dcache_ctrl_if.slave (processor + memory sides)
//            hit_cnt, miss_cnt  read lookup statistics (optional)
//  Options : L1_DCACHE_STATS_EN adds the hit_cnt/miss_cnt outputs.
//  Rev     : 1.0  initial release
// ============================================================================
module l1_dcache_ctrl
    import l1_dcache_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DC_ADDR_W,
    parameter int WORD_W  = DC_WORD_W,
    parameter int INDEX_W = DC_INDEX_W
) (
    input  wire logic          clk,
    input  wire logic          reset,
    l1_dcache_ctrl_if.slave    bus
`ifdef L1_DCACHE_STATS_EN
    ,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt
`endif
);
    localparam int TAG_W = ADDR_W - INDEX_W;

    state_t              r_state;
    logic [IOSTATE_W-1:0] r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_wdata;

    logic [WORD_W-1:0]    r_cpu_rdata;
    logic                 r_cpu_rd_en;
    logic                 r_cpu_wt_en;
    logic [IOSTATE_W-1:0] r_mem_rw;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [WORD_W-1:0]    r_mem_wdata;

    logic                w_line_valid;
    logic [TAG_W-1:0]    w_line_tag;
    logic [WORD_W-1:0]   w_line_data;
    logic                w_hit;
    logic                w_arr_we;
    logic [WORD_W-1:0]   w_arr_wdata;

    // Lookup always uses the latched address, so the array output is stable
    // for the whole transaction regardless of what the CPU does to its bus.
    assign w_hit = w_line_valid && (w_line_tag == r_addr[ADDR_W-1:INDEX_W]);

    // A fill always allocates; a write only refreshes a line that is
    // already resident (no allocate on write miss).
    assign w_arr_we    = ((r_state == ST_FILL)  && bus.mem_rd_done) ||
                         ((r_state == ST_WRITE) && bus.mem_wt_done && w_hit);
    assign w_arr_wdata = (r_state == ST_FILL) ? bus.mem_rdata : r_wdata;

    l1_dcache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .WORD_W  (WORD_W)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .i_rd_index (r_addr[INDEX_W-1:0]),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_we       (w_arr_we),
        .i_wr_index (r_addr[INDEX_W-1:0]),
        .i_wr_tag   (r_addr[ADDR_W-1:INDEX_W]),
        .i_wr_data  (w_arr_wdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= IO_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_cpu_rd_en <= 1'b0;
            r_cpu_wt_en <= 1'b0;
            r_mem_rw    <= IO_IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cpu_rw == IO_RD || bus.cpu_rw == IO_WT) begin
                        r_op    <= bus.cpu_rw;
                        r_addr  <= bus.cpu_addr;
                        r_wdata <= bus.cpu_wdata;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (r_op == IO_RD) begin
                        if (w_hit) begin
                            r_cpu_rdata <= w_line_data;
                            r_cpu_rd_en <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_mem_rw    <= IO_RD;
                            r_mem_addr  <= r_addr;
                            r_state     <= ST_FILL;
                        end
                    end else begin
                        r_mem_rw    <= IO_WT;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= r_wdata;
                        r_state     <= ST_WRITE;
                    end
                end
                ST_FILL: begin
                    if (bus.mem_rd_done) begin
                        r_cpu_rdata <= bus.mem_rdata;
                        r_cpu_rd_en <= 1'b1;
                        r_mem_rw    <= IO_IDLE;
                        r_state     <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    if (bus.mem_wt_done) begin
                        r_cpu_wt_en <= 1'b1;
                        r_mem_rw    <= IO_IDLE;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // The requester drops cpu_rw on the edge it samples the
                    // pulse, so nothing is accepted here.
                    r_cpu_rd_en <= 1'b0;
                    r_cpu_wt_en <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.cpu_rd_en = r_cpu_rd_en;
    assign bus.cpu_wt_en = r_cpu_wt_en;
    assign bus.mem_rw    = r_mem_rw;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

`ifdef L1_DCACHE_STATS_EN
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    // Only read lookups are counted; writes never consult the hit result
    // for the processor response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == ST_LOOKUP && r_op == IO_RD) begin
            if (w_hit) begin
                r_hit_cnt  <= sat_inc(r_hit_cnt);
            end else begin
                r_miss_cnt <= sat_inc(r_miss_cnt);
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_l1_dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_l1_dcache_ctrl
//  Purpose : Self-checking bench for l1_dcache_ctrl. Directed transaction
//            table plus hand sequences for reset-in-fill, illegal requests,
//            stray memory done strobes and (optionally) the statistics.
//            A behavioural main memory answers every request MEM_LAT cycles
//            after it appears.
//  Options : L1_DCACHE_STATS_EN enables the statistics sequence.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_l1_dcache_ctrl;
    import l1_dcache_ctrl_pkg::*;

    localparam int MEM_LAT = 3;
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    l1_dcache_ctrl_if bus ();

`ifdef L1_DCACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    l1_dcache_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef L1_DCACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    // ---------------- behavioural main memory ----------------
    logic [7:0] mem [256];
    logic       mem_init = 1'b0;
    int         mem_cnt  = 0;
    logic       inj_done = 1'b0;   // stray done strobes for the ignore test

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
            mem[8'h35] = 8'hA7;
            mem[8'h45] = 8'h3C;
            bus.mem_rdata = 8'h00;
            mem_init = 1'b1;
        end
        bus.mem_rd_done = inj_done;
        bus.mem_wt_done = inj_done;
        if (bus.mem_rw == IO_RD || bus.mem_rw == IO_WT) begin
            mem_cnt++;
            if (mem_cnt == MEM_LAT) begin
                mem_cnt = 0;
                if (bus.mem_rw == IO_RD) begin
                    bus.mem_rdata   = mem[bus.mem_addr];
                    bus.mem_rd_done = 1'b1;
                end else begin
                    mem[bus.mem_addr] = bus.mem_wdata;
                    bus.mem_wt_done   = 1'b1;
                end
            end
        end else begin
            mem_cnt = 0;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Observations from the last transaction.
    logic       t_got, t_rd, t_wt, t_saw_mem, t_after;
    int         t_lat;
    logic [7:0] t_rdata, t_maddr, t_mwdata;
    logic [1:0] t_mrw;

    // Starts at #1 after a rising edge (cycle 0 = first cycle of request).
    task automatic run_txn(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata);
        int cyc;
        t_got = 0; t_rd = 0; t_wt = 0; t_saw_mem = 0; t_lat = -1;
        t_rdata = 0; t_maddr = 0; t_mwdata = 0; t_mrw = 0;
        bus.cpu_rw    = op;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        cyc = 0;
        while (!t_got && cyc < TIMEOUT) begin
            @(negedge clk);
            if (!t_saw_mem && bus.mem_rw != IO_IDLE) begin
                t_saw_mem = 1; t_mrw = bus.mem_rw;
                t_maddr = bus.mem_addr; t_mwdata = bus.mem_wdata;
            end
            if (bus.cpu_rd_en || bus.cpu_wt_en) begin
                t_got = 1; t_lat = cyc;
                t_rd = bus.cpu_rd_en; t_wt = bus.cpu_wt_en; t_rdata = bus.cpu_rdata;
            end
            @(posedge clk); #1;
            cyc++;
            // Bus changes after the latch edge must not matter.
            if (cyc == 1) begin
                bus.cpu_addr  = ~addr;
                bus.cpu_wdata = ~wdata;
            end
        end
        bus.cpu_rw = IO_IDLE;
        @(negedge clk);
        t_after = bus.cpu_rd_en | bus.cpu_wt_en | (bus.mem_rw != IO_IDLE);
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus.cpu_rw = IO_IDLE;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       mem_acc;   // memory request expected
        logic [7:0] rdata;     // expected read data (reads only)
        int         lat;       // expected pulse cycle
    } vec_t;

    vec_t vecs [12];

    task automatic apply_vec(input vec_t v, input string tag);
        run_txn(v.op, v.addr, v.wdata);
        check({tag, ".done"}, 32'(t_got), 32'd1);
        if (t_got) begin
            check({tag, ".lat"}, 32'(t_lat), 32'(v.lat));
            check({tag, ".rd_en"}, 32'(t_rd), 32'(v.op == IO_RD));
            check({tag, ".wt_en"}, 32'(t_wt), 32'(v.op == IO_WT));
            if (v.op == IO_RD) check({tag, ".rdata"}, 32'(t_rdata), 32'(v.rdata));
        end
        check({tag, ".mem_acc"}, 32'(t_saw_mem), 32'(v.mem_acc));
        if (v.mem_acc && t_saw_mem) begin
            check({tag, ".mem_rw"}, 32'(t_mrw), 32'(v.op));
            check({tag, ".mem_addr"}, 32'(t_maddr), 32'(v.addr));
            if (v.op == IO_WT) check({tag, ".mem_wdata"}, 32'(t_mwdata), 32'(v.wdata));
        end
        check({tag, ".quiet_after"}, 32'(t_after), 32'd0);
    endtask

    initial begin
        logic bad;
        bus.cpu_rw = IO_IDLE; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        // read miss 0x35 / hit; conflicting 0x45 evicts; write-update;
        // write miss leaves the line alone; write miss not allocated.
        vecs[0]  = '{IO_RD, 8'h35, 8'h00, 1'b1, 8'hA7, 5};
        vecs[1]  = '{IO_RD, 8'h35, 8'h00, 1'b0, 8'hA7, 2};
        vecs[2]  = '{IO_RD, 8'h45, 8'h00, 1'b1, 8'h3C, 5};
        vecs[3]  = '{IO_RD, 8'h35, 8'h00, 1'b1, 8'hA7, 5};
        vecs[4]  = '{IO_WT, 8'h35, 8'h5C, 1'b1, 8'h00, 5};
        vecs[5]  = '{IO_RD, 8'h35, 8'h00, 1'b0, 8'h5C, 2};
        vecs[6]  = '{IO_WT, 8'h45, 8'h77, 1'b1, 8'h00, 5};
        vecs[7]  = '{IO_RD, 8'h35, 8'h00, 1'b0, 8'h5C, 2};
        vecs[8]  = '{IO_RD, 8'h45, 8'h00, 1'b1, 8'h77, 5};
        vecs[9]  = '{IO_WT, 8'h12, 8'h99, 1'b1, 8'h00, 5};
        vecs[10] = '{IO_RD, 8'h12, 8'h00, 1'b1, 8'h99, 5};
        vecs[11] = '{IO_RD, 8'h12, 8'h00, 1'b0, 8'h99, 2};

        do_reset();
        @(negedge clk);
        check("rst.cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        check("rst.cpu_rd_en", 32'(bus.cpu_rd_en), 32'd0);
        check("rst.cpu_wt_en", 32'(bus.cpu_wt_en), 32'd0);
        check("rst.mem_rw",    32'(bus.mem_rw),    32'(IO_IDLE));
        check("rst.mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst.mem_wdata", 32'(bus.mem_wdata), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) apply_vec(vecs[i], $sformatf("v%0d", i));

        // Illegal request code and stray done strobes while idle: no effect.
        bus.cpu_rw = 2'd3;
        inj_done = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.cpu_rd_en || bus.cpu_wt_en || bus.mem_rw != IO_IDLE) bad = 1;
            @(posedge clk); #1;
        end
        bus.cpu_rw = IO_IDLE;
        inj_done = 1'b0;
        @(negedge clk);
        if (bus.cpu_rd_en || bus.cpu_wt_en || bus.mem_rw != IO_IDLE) bad = 1;
        check("ign.rw3_done", 32'(bad), 32'd0);
        @(posedge clk); #1;
        // Still a hit afterwards: stray strobes did not disturb the array.
        apply_vec('{IO_RD, 8'h12, 8'h00, 1'b0, 8'h99, 2}, "ign.hit");

        // Reset while a fill for 0x35 is outstanding (index 5 holds 0x45).
        bus.cpu_rw = IO_RD; bus.cpu_addr = 8'h35;
        repeat (3) begin @(posedge clk); #1; end   // now cycle 3, in FILL
        bus.cpu_rw = IO_IDLE;
        reset = 1'b1;
        @(negedge clk);
        check("rf.mem_rw_before", 32'(bus.mem_rw), 32'(IO_RD));
        @(posedge clk); #1;
        reset = 1'b0;
        bad = 0;
        @(negedge clk);
        check("rf.mem_rw_next", 32'(bus.mem_rw), 32'(IO_IDLE));
        repeat (6) begin
            if (bus.cpu_rd_en || bus.cpu_wt_en || bus.mem_rw != IO_IDLE) bad = 1;
            @(negedge clk);
        end
        check("rf.no_pulse", 32'(bad), 32'd0);
        @(posedge clk); #1;
        apply_vec('{IO_RD, 8'h35, 8'h00, 1'b1, 8'h5C, 5}, "rf.miss");
        apply_vec('{IO_RD, 8'h12, 8'h00, 1'b1, 8'h99, 5}, "rf.miss12");

`ifdef L1_DCACHE_STATS_EN
        do_reset();
        @(negedge clk);
        check("st.rst_hit",  32'(hit_cnt),  32'd0);
        check("st.rst_miss", 32'(miss_cnt), 32'd0);
        @(posedge clk); #1;
        run_txn(IO_RD, 8'h35, 8'h00);
        run_txn(IO_RD, 8'h35, 8'h00);
        run_txn(IO_RD, 8'h35, 8'h00);
        run_txn(IO_WT, 8'h35, 8'h11);
        @(negedge clk);
        check("st.hit",  32'(hit_cnt),  32'd2);
        check("st.miss", 32'(miss_cnt), 32'd1);
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        check("st.hit_clr",  32'(hit_cnt),  32'd0);
        check("st.miss_clr", 32'(miss_cnt), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
